// File: rtl/hvsp_pkg.sv
// rtl/hvsp_pkg.sv - shared constants and types for the HVSP programming sequencer
// Op codes, result error codes, FSM state encoding and SII instruction bytes.
package hvsp_pkg;

    localparam logic [2:0] OP_CHIP_ERASE    = 3'd0;
    localparam logic [2:0] OP_READ_SIG      = 3'd1;
    localparam logic [2:0] OP_READ_FLASH_LO = 3'd2;
    localparam logic [2:0] OP_READ_FUSE_LO  = 3'd3;
    localparam logic [2:0] OP_WRITE_FUSE_LO = 3'd4;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;

    localparam logic [7:0] SII_LD_CMD     = 8'h4C;
    localparam logic [7:0] SII_LD_ADDR_LO = 8'h0C;
    localparam logic [7:0] SII_LD_ADDR_HI = 8'h1C;
    localparam logic [7:0] SII_LD_DATA_LO = 8'h2C;
    localparam logic [7:0] SII_WR_LO      = 8'h64;
    localparam logic [7:0] SII_RD_LO      = 8'h68;
    localparam logic [7:0] SII_RD_LO_END  = 8'h6C;

    localparam int FRAME_IDX_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_FRAME,
        ST_POLL,
        ST_DONE
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_WRITE_FUSE_LO;
    endfunction

    // Erase and write leave the target busy; completion is signalled on SDO.
    function automatic logic op_needs_poll(input logic [2:0] op);
        return (op == OP_CHIP_ERASE) || (op == OP_WRITE_FUSE_LO);
    endfunction

endpackage

// File: rtl/hvsp_frame_rom.sv
// rtl/hvsp_frame_rom.sv - combinational SDI/SII frame table per op and frame index
// The final entry of each op is the default index so o_last is never missed.
module hvsp_frame_rom
    import hvsp_pkg::*;
(
    input  logic [2:0]             i_op,
    input  logic [FRAME_IDX_W-1:0] i_index,
    input  logic [9:0]             i_addr,
    input  logic [7:0]             i_wdata,
    output logic [7:0]             o_sdi,
    output logic [7:0]             o_sii,
    output logic                   o_last
);

    always_comb begin
        o_sdi  = 8'h00;
        o_sii  = 8'h00;
        o_last = 1'b1;
        case (i_op)
            OP_CHIP_ERASE: case (i_index)
                3'd0:    begin o_sdi = 8'h80; o_sii = SII_LD_CMD; o_last = 1'b0; end
                3'd1:    begin o_sii = SII_WR_LO; o_last = 1'b0; end
                default: o_sii = SII_RD_LO_END;
            endcase
            OP_READ_SIG: case (i_index)
                3'd0:    begin o_sdi = 8'h08; o_sii = SII_LD_CMD; o_last = 1'b0; end
                3'd1:    begin o_sdi = i_addr[7:0]; o_sii = SII_LD_ADDR_LO; o_last = 1'b0; end
                3'd2:    begin o_sii = SII_RD_LO; o_last = 1'b0; end
                default: o_sii = SII_RD_LO_END;
            endcase
            OP_READ_FLASH_LO: case (i_index)
                3'd0:    begin o_sdi = 8'h02; o_sii = SII_LD_CMD; o_last = 1'b0; end
                3'd1:    begin o_sdi = i_addr[7:0]; o_sii = SII_LD_ADDR_LO; o_last = 1'b0; end
                3'd2:    begin o_sdi = {6'b0, i_addr[9:8]}; o_sii = SII_LD_ADDR_HI; o_last = 1'b0; end
                3'd3:    begin o_sii = SII_RD_LO; o_last = 1'b0; end
                default: o_sii = SII_RD_LO_END;
            endcase
            OP_READ_FUSE_LO: case (i_index)
                3'd0:    begin o_sdi = 8'h04; o_sii = SII_LD_CMD; o_last = 1'b0; end
                3'd1:    begin o_sii = SII_RD_LO; o_last = 1'b0; end
                default: o_sii = SII_RD_LO_END;
            endcase
            OP_WRITE_FUSE_LO: case (i_index)
                3'd0:    begin o_sdi = 8'h40; o_sii = SII_LD_CMD; o_last = 1'b0; end
                3'd1:    begin o_sdi = i_wdata; o_sii = SII_LD_DATA_LO; o_last = 1'b0; end
                3'd2:    begin o_sii = SII_WR_LO; o_last = 1'b0; end
                default: o_sii = SII_RD_LO_END;
            endcase
            default: ;
        endcase
    end

endmodule

// File: rtl/hvsp_sequencer.sv
// rtl/hvsp_sequencer.sv - HVSP op sequencer: issues frame tables, captures reads, polls SDO
// Host ops are accepted only in IDLE; results hold until the next op is accepted.
module hvsp_sequencer
    import hvsp_pkg::*;
#(
    parameter int POLL_TIMEOUT = 240000
) (
    input  logic        osc,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [9:0]  op_addr,
    input  logic [7:0]  op_wdata,
    output logic        op_ready,
    output logic        frame_valid,
    output logic [7:0]  frame_sdi,
    output logic [7:0]  frame_sii,
    input  logic        frame_ready,
    input  logic        frame_done,
    input  logic [10:0] frame_sdo,
    input  logic        sdo_pin,
    output logic        result_valid,
    output logic [7:0]  result_data,
    output logic [1:0]  result_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);

    state_e                 r_state;
    state_e                 w_next;
    logic [2:0]             r_op;
    logic [9:0]             r_addr;
    logic [7:0]             r_wdata;
    logic [FRAME_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [7:0]             r_rdata;
    logic [1:0]             r_err;
    logic [7:0]             w_sdi;
    logic [7:0]             w_sii;
    logic                   w_last;
    logic                   w_poll_end;
    logic                   w_unused;

    hvsp_frame_rom u_rom (
        .i_op    (r_op),
        .i_index (r_idx),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_sdi   (w_sdi),
        .o_sii   (w_sii),
        .o_last  (w_last)
    );

    assign w_poll_end = (r_cnt == CNT_W'(POLL_TIMEOUT - 1));
    assign w_unused   = ^frame_sdo[2:0];

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:       if (op_valid) w_next = op_is_legal(op_code) ? ST_ISSUE : ST_DONE;
            ST_ISSUE:      if (frame_ready) w_next = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (frame_done) begin
                if (!w_last)                 w_next = ST_ISSUE;
                else if (op_needs_poll(r_op)) w_next = ST_POLL;
                else                         w_next = ST_DONE;
            end
            ST_POLL:       if (sdo_pin || w_poll_end) w_next = ST_DONE;
            ST_DONE:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: if (op_valid) begin
                    r_op    <= op_code;
                    r_addr  <= op_addr;
                    r_wdata <= op_wdata;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    r_rdata <= '0;
                    r_err   <= op_is_legal(op_code) ? ERR_OK : ERR_ILLEGAL;
                end
                ST_WAIT_FRAME: if (frame_done) begin
                    if (w_last) r_rdata <= frame_sdo[10:3];
                    else        r_idx   <= r_idx + 1'b1;
                end
                // A ready SDO on the terminal count still counts as success.
                ST_POLL: if (!sdo_pin) begin
                    if (w_poll_end) r_err <= ERR_TIMEOUT;
                    else            r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign op_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign frame_valid  = (r_state == ST_ISSUE);
    assign frame_sdi    = frame_valid ? w_sdi : 8'h00;
    assign frame_sii    = frame_valid ? w_sii : 8'h00;
    assign result_valid = (r_state == ST_DONE);
    assign result_data  = r_rdata;
    assign result_err   = r_err;

endmodule

// File: tb/tb_hvsp_sequencer.sv
// tb/tb_hvsp_sequencer.sv - directed self-checking bench for hvsp_sequencer
module tb_hvsp_sequencer;

    localparam int T = 1500;

    logic        osc = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [9:0]  op_addr;
    logic [7:0]  op_wdata;
    logic        op_ready;
    logic        frame_valid;
    logic [7:0]  frame_sdi;
    logic [7:0]  frame_sii;
    logic        frame_ready;
    logic        frame_done;
    logic [10:0] frame_sdo;
    logic        sdo_pin;
    logic        result_valid;
    logic [7:0]  result_data;
    logic [1:0]  result_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    hvsp_sequencer #(.POLL_TIMEOUT(T)) dut (
        .osc          (osc),
        .rst_n        (rst_n),
        .op_valid     (op_valid),
        .op_code      (op_code),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .op_ready     (op_ready),
        .frame_valid  (frame_valid),
        .frame_sdi    (frame_sdi),
        .frame_sii    (frame_sii),
        .frame_ready  (frame_ready),
        .frame_done   (frame_done),
        .frame_sdo    (frame_sdo),
        .sdo_pin      (sdo_pin),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_err   (result_err),
        .busy         (busy)
    );

    always #5 osc = ~osc;

    task automatic tick;
        @(negedge osc);
    endtask

    task automatic issue_op(input logic [2:0] code, input logic [9:0] addr, input logic [7:0] wdata);
        op_code  = code;
        op_addr  = addr;
        op_wdata = wdata;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    // Frame shifter model: accept after rdly cycles, then pulse frame_done with sdo.
    task automatic shift_frame(input logic [7:0] esdi, input logic [7:0] esii, input int rdly,
                               input logic [10:0] sdo, input string tag);
        int waited = 0;
        while (frame_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s frame_valid: got %b want 1", tag, frame_valid);
        end
        n_checks++;
        if (frame_sdi !== esdi || frame_sii !== esii) begin
            n_fail++;
            $display("FAIL %s frame: got %h/%h want %h/%h", tag, frame_sdi, frame_sii, esdi, esii);
        end
        for (int i = 0; i < rdly; i++) begin
            tick();
            n_checks++;
            if (frame_valid !== 1'b1 || frame_sdi !== esdi || frame_sii !== esii) begin
                n_fail++;
                $display("FAIL %s hold: got %b %h/%h want 1 %h/%h", tag, frame_valid, frame_sdi, frame_sii, esdi, esii);
            end
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid_drop: got %b want 0", tag, frame_valid);
        end
        tick();
        frame_sdo  = sdo;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        frame_sdo  = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op_valid = 0; op_code = 0; op_addr = 0; op_wdata = 0;
        frame_ready = 0; frame_done = 0; frame_sdo = 0; sdo_pin = 0;
        repeat (3) tick();
        n_checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || frame_valid !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b fv=%b rv=%b want 1 0 0 0", op_ready, busy, frame_valid, result_valid);
        end
        n_checks++;
        if (frame_sdi !== 8'h00 || frame_sii !== 8'h00 || result_data !== 8'h00 || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %0d want 00 00 00 0", frame_sdi, frame_sii, result_data, result_err);
        end
        rst_n = 1'b1;
        tick();
        frame_sdo = 11'h7FF; frame_done = 1'b1;
        tick();
        frame_done = 1'b0; frame_sdo = 0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || frame_valid !== 1'b0 || result_valid !== 1'b0 || result_data !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_done_ignored: got busy=%b fv=%b rv=%b data=%h want 0 0 0 00", busy, frame_valid, result_valid, result_data);
        end
    endtask

    task automatic test_read_sig;
        issue_op(3'd1, 10'h001, 8'h00);
        n_checks++;
        if (frame_valid !== 1'b1 || busy !== 1'b1 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sig_latency: got fv=%b busy=%b rdy=%b want 1 1 0", frame_valid, busy, op_ready);
        end
        shift_frame(8'h08, 8'h4C, 0, 11'h000, "sig0");
        shift_frame(8'h01, 8'h0C, 0, 11'h000, "sig1");
        shift_frame(8'h00, 8'h68, 0, 11'h000, "sig2");
        shift_frame(8'h00, 8'h6C, 0, 11'h4B0, "sig3");
        n_checks++;
        if (result_valid !== 1'b1 || result_data !== 8'h96 || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL sig_result: got rv=%b data=%h err=%0d want 1 96 0", result_valid, result_data, result_err);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result_data !== 8'h96) begin
            n_fail++;
            $display("FAIL sig_after: got rv=%b busy=%b data=%h want 0 0 96", result_valid, busy, result_data);
        end
    endtask

    task automatic test_read_flash;
        issue_op(3'd2, 10'h2A5, 8'h00);
        shift_frame(8'h02, 8'h4C, 3, 11'h000, "fl0");
        shift_frame(8'hA5, 8'h0C, 3, 11'h000, "fl1");
        shift_frame(8'h02, 8'h1C, 3, 11'h000, "fl2");
        shift_frame(8'h00, 8'h68, 3, 11'h000, "fl3");
        shift_frame(8'h00, 8'h6C, 3, 11'h555, "fl4");
        n_checks++;
        if (result_valid !== 1'b1 || result_data !== 8'hAA || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL flash_result: got rv=%b data=%h err=%0d want 1 aa 0", result_valid, result_data, result_err);
        end
        tick();
    endtask

    task automatic test_chip_erase;
        int pulses = 0;
        issue_op(3'd0, 10'h000, 8'h00);
        shift_frame(8'h80, 8'h4C, 0, 11'h000, "er0");
        shift_frame(8'h00, 8'h64, 0, 11'h000, "er1");
        shift_frame(8'h00, 8'h6C, 0, 11'h000, "er2");
        sdo_pin = 1'b0;
        repeat (999) begin
            if (result_valid === 1'b1) pulses++;
            tick();
        end
        sdo_pin = 1'b1;
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL erase_result: got rv=%b err=%0d want 1 0", result_valid, result_err);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL erase_busy: got %b want 0", busy);
        end
        repeat (4) begin
            if (result_valid === 1'b1) pulses++;
            tick();
        end
        sdo_pin = 1'b0;
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL erase_pulses: got %0d extra want 0", pulses);
        end
    endtask

    task automatic test_write_fuse_timeout;
        int seen = -1;
        issue_op(3'd4, 10'h000, 8'h6A);
        shift_frame(8'h40, 8'h4C, 0, 11'h000, "wf0");
        shift_frame(8'h6A, 8'h2C, 0, 11'h000, "wf1");
        shift_frame(8'h00, 8'h64, 0, 11'h000, "wf2");
        shift_frame(8'h00, 8'h6C, 0, 11'h7F8, "wf3");
        sdo_pin = 1'b0;
        for (int i = 1; i <= T + 5 && seen < 0; i++) begin
            tick();
            if (result_valid === 1'b1) seen = i;
        end
        n_checks++;
        if (seen != T) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d want %0d", seen, T);
        end
        n_checks++;
        if (result_err !== 2'd1 || result_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%0d data=%h want 1 ff", result_err, result_data);
        end
        tick();
    endtask

    task automatic test_poll_boundary;
        issue_op(3'd0, 10'h000, 8'h00);
        shift_frame(8'h80, 8'h4C, 0, 11'h000, "pb0");
        shift_frame(8'h00, 8'h64, 0, 11'h000, "pb1");
        shift_frame(8'h00, 8'h6C, 0, 11'h000, "pb2");
        repeat (T - 1) tick();
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_early: got rv=%b busy=%b want 0 1", result_valid, busy);
        end
        sdo_pin = 1'b1;
        tick();
        sdo_pin = 1'b0;
        n_checks++;
        if (result_valid !== 1'b1 || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL boundary_win: got rv=%b err=%0d want 1 0", result_valid, result_err);
        end
        tick();
    endtask

    task automatic test_illegal;
        issue_op(3'd6, 10'h3FF, 8'hFF);
        n_checks++;
        if (result_valid !== 1'b1 || result_err !== 2'd2 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal: got rv=%b err=%0d fv=%b want 1 2 0", result_valid, result_err, frame_valid);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0 || result_err !== 2'd2) begin
            n_fail++;
            $display("FAIL illegal_after: got rv=%b busy=%b fv=%b err=%0d want 0 0 0 2", result_valid, busy, frame_valid, result_err);
        end
    endtask

    task automatic test_busy_ignore;
        int stray = 0;
        issue_op(3'd3, 10'h000, 8'h00);
        op_code  = 3'd0;
        op_valid = 1'b1;
        n_checks++;
        if (op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: got %b want 0", op_ready);
        end
        shift_frame(8'h04, 8'h4C, 2, 11'h000, "fu0");
        op_valid = 1'b0;
        shift_frame(8'h00, 8'h68, 0, 11'h000, "fu1");
        shift_frame(8'h00, 8'h6C, 0, 11'h1A8, "fu2");
        n_checks++;
        if (result_valid !== 1'b1 || result_data !== 8'h35 || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL fuse_result: got rv=%b data=%h err=%0d want 1 35 0", result_valid, result_data, result_err);
        end
        repeat (6) begin
            tick();
            if (frame_valid === 1'b1 || busy === 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL busy_queued: got %0d active cycles want 0", stray);
        end
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        issue_op(3'd1, 10'h055, 8'h00);
        shift_frame(8'h08, 8'h4C, 0, 11'h000, "rm0");
        n_checks++;
        if (frame_valid !== 1'b1 || frame_sdi !== 8'h55) begin
            n_fail++;
            $display("FAIL rm_second: got fv=%b sdi=%h want 1 55", frame_valid, frame_sdi);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (frame_valid !== 1'b0 || busy !== 1'b0 || frame_sdi !== 8'h00) begin
            n_fail++;
            $display("FAIL rm_async: got fv=%b busy=%b sdi=%h want 0 0 00", frame_valid, busy, frame_sdi);
        end
        tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (frame_valid === 1'b1 || result_valid === 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rm_stray: got %0d active cycles want 0", stray);
        end
        issue_op(3'd1, 10'h002, 8'h00);
        shift_frame(8'h08, 8'h4C, 1, 11'h000, "rn0");
        shift_frame(8'h02, 8'h0C, 0, 11'h000, "rn1");
        shift_frame(8'h00, 8'h68, 0, 11'h000, "rn2");
        shift_frame(8'h00, 8'h6C, 0, 11'h123, "rn3");
        n_checks++;
        if (result_valid !== 1'b1 || result_data !== 8'h24 || result_err !== 2'd0) begin
            n_fail++;
            $display("FAIL rm_rerun: got rv=%b data=%h err=%0d want 1 24 0", result_valid, result_data, result_err);
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_sig();
        test_read_flash();
        test_chip_erase();
        test_write_fuse_timeout();
        test_poll_boundary();
        test_illegal();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hvsp_sequencer.md
HVSP_SEQUENCER -- requirements
Module: hvsp_sequencer

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 240000, meaning the SDO-ready poll limit in osc cycles (10 ms at 24 MHz).
REQ-002 SHALL have port osc  in  1  24 MHz clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports op_valid in 1; op_code in 3; op_addr in 10; op_wdata in 8; op_ready out 1 (host operation request).
REQ-005 SHALL have ports frame_valid out 1; frame_sdi out 8; frame_sii out 8; frame_ready in 1 (request to the 11-bit frame shifter).
REQ-006 SHALL have ports frame_done in 1 (one-cycle pulse when a frame has fully shifted); frame_sdo in 11 (captured SDO frame, valid with frame_done); sdo_pin in 1 (raw SDO level).
REQ-007 SHALL have ports result_valid out 1; result_data out 8; result_err out 2 (0 ok, 1 timeout, 2 illegal op); busy out 1.

Function
REQ-008 SHALL support op codes: 0 CHIP_ERASE, 1 READ_SIG, 2 READ_FLASH_LO, 3 READ_FUSE_LO, 4 WRITE_FUSE_LO; codes 5-7 are illegal.
REQ-009 Frame tables (SDI/SII, in order) SHALL be: CHIP_ERASE 80/4C, 00/64, 00/6C, then poll; READ_SIG 08/4C, addr[7:0]/0C, 00/68, 00/6C; READ_FLASH_LO 02/4C, addr[7:0]/0C, {6'b0,addr[9:8]}/1C, 00/68, 00/6C; READ_FUSE_LO 04/4C, 00/68, 00/6C; WRITE_FUSE_LO 40/4C, wdata/2C, 00/64, 00/6C, then poll.
REQ-010 States SHALL be IDLE, ISSUE, WAIT_FRAME, POLL, DONE.
REQ-011 IDLE: op_ready=1; on op_valid=1, op_code/op_addr/op_wdata SHALL be latched, frame index cleared, next state ISSUE (illegal code: DONE with result_err=2).
REQ-012 ISSUE: frame_valid=1 with table entry of current index held stable; on frame_ready=1 in the same cycle, next state WAIT_FRAME, frame_valid deasserts next cycle.
REQ-013 WAIT_FRAME: on frame_done, if entry is last, capture result_data=frame_sdo[10:3] and go POLL (erase/write) or DONE; else increment index and go ISSUE.
REQ-014 POLL: count osc cycles from 0; sdo_pin=1 -> DONE err 0; count reaching POLL_TIMEOUT-1 without sdo_pin -> DONE err 1; sdo_pin=1 on that terminal cycle SHALL win (err 0).
REQ-015 DONE: result_valid=1 for exactly one cycle, then IDLE; result_data/result_err hold until next op is accepted.
REQ-016 busy SHALL equal (state != IDLE); op_valid while busy SHALL be ignored, not queued.
REQ-017 frame_done outside WAIT_FRAME SHALL be ignored.
REQ-018 Latency: op accept to first frame_valid SHALL be 1 cycle; last frame_done to result_valid SHALL be 1 cycle for read ops.
REQ-019 Poll counter SHALL be wide enough for POLL_TIMEOUT and SHALL not wrap.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, op_ready=1, frame_valid=0, frame_sdi=frame_sii=0, result_valid=0, result_data=0, result_err=0, busy=0, counters 0.
REQ-021 Reset mid-operation SHALL abandon the sequence with no result_valid pulse; no frame_valid after deassertion until a new op.

Structure
REQ-022 Op codes, error codes, state enum and SII instruction constants SHALL live in shared package hvsp_pkg.
REQ-023 Frame table SHALL be sub-module hvsp_frame_rom (combinational: op, index, addr, wdata -> sdi, sii, last).

Verification
REQ-024 READ_SIG addr=0x01, shifter model returns frame_sdo=0x4B0 on last frame -> frames 08/4C, 01/0C, 00/68, 00/6C; result_data=0x96, err 0.
REQ-025 READ_FLASH_LO addr=0x2A5, frame_ready delayed 3 cycles per frame -> third frame SDI=0x02, SII=0x1C; frame_valid held stable across wait.
REQ-026 CHIP_ERASE, sdo_pin rises 1000 cycles after last frame_done -> result_valid once, err 0, busy low next cycle.
REQ-027 WRITE_FUSE_LO wdata=0x6A, sdo_pin stuck 0 -> result_valid exactly POLL_TIMEOUT cycles into POLL, err 1.
REQ-028 op_code=6 -> no frame_valid, result_err=2; op_valid during busy ignored.
REQ-029 rst_n low during second frame of READ_SIG -> frame_valid=0 immediately, no result_valid, next op runs normally.
